scroll_display_engine: RTL and testbench

- Parametrised successor to the UART-to-7-segment scroller path.
- Accepts ASCII bytes from the UART receive side, buffers them in an internal FIFO and decodes them to digit codes.
- Scrolls an N-digit window left or right at a selectable rate, with hold and clear modes.
- Feeds per-digit DEC2SEG-style decoders.

---
 rtl/scroll_display_engine.sv | 165 ++++++++++++++++
 tb/tb_scroll_display_engine.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_display_engine.sv
// Character scroller: buffers decoded ASCII digits/spaces in a small FIFO and
// shifts them through an N-digit window at a selectable rate.
module scroll_display_engine #(
    parameter int NUM_DIGITS  = 3,
    parameter int FIFO_DEPTH  = 16,
    parameter int STEP_CYCLES = 50000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_valid,
    input  logic [7:0]              i_data,
    input  logic [1:0]              i_rate,
    input  logic [1:0]              i_mode,
    output logic                    o_ready,
    output logic                    o_drop,
    output logic                    o_step,
    output logic [4*NUM_DIGITS-1:0] o_digits,
    output logic [NUM_DIGITS-1:0]   o_blank,
    output logic                    o_fifo_empty,
    output logic                    o_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STEP_CYCLES * 8 + 1);
    localparam logic [CW-1:0] STEP_W = CW'(STEP_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_CLEAR} state_t;

    state_t                state_q;
    logic [4:0]            mem_q [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic                  full_q, empty_q, full_d, empty_d;
    logic [CW-1:0]         count_q, period_m1;
    logic [3:0]            code_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blank_q;
    logic                  drop_q, step_q;

    logic                  is_digit, is_space, decodable;
    logic                  clear_go, flush, do_step, wr_en, rd_en;
    logic [4:0]            wr_entry, head;
    logic [3:0]            left_code [NUM_DIGITS];
    logic [3:0]            right_code [NUM_DIGITS];
    logic [3:0]            step_code [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] left_blank, right_blank, step_blank;

    always_comb begin
        is_digit  = (i_data >= 8'h30) && (i_data <= 8'h39);
        is_space  = (i_data == 8'h20);
        decodable = is_digit || is_space;
        // FIFO entry layout is {blank, code}; a space carries code 0.
        wr_entry  = is_space ? 5'b1_0000 : {1'b0, i_data[3:0]};

        period_m1 = (STEP_W << (2'd3 - i_rate)) - CW'(1);
        clear_go  = (i_mode == 2'b11) && (state_q != S_CLEAR);
        flush     = clear_go || (state_q == S_CLEAR);
        // Greater-or-equal so a faster rate chosen mid-count steps at once.
        do_step   = (state_q == S_RUN) && !i_mode[1] && (count_q >= period_m1);
        wr_en     = i_valid && decodable && !full_q && !flush;
        rd_en     = do_step && !empty_q;
        head      = empty_q ? 5'b1_0000 : mem_q[rd_ptr_q[AW-1:0]];

        wr_ptr_d  = flush ? '0 : wr_ptr_q + (AW+1)'(wr_en);
        rd_ptr_d  = flush ? '0 : rd_ptr_q + (AW+1)'(rd_en);
        empty_d   = (wr_ptr_d == rd_ptr_d);
        full_d    = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                    (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_left
                assign left_code[gi]  = head[3:0];
                assign left_blank[gi] = head[4];
            end else begin : g_left
                assign left_code[gi]  = code_q[gi-1];
                assign left_blank[gi] = blank_q[gi-1];
            end
            if (gi == NUM_DIGITS - 1) begin : g_right
                assign right_code[gi]  = head[3:0];
                assign right_blank[gi] = head[4];
            end else begin : g_right
                assign right_code[gi]  = code_q[gi+1];
                assign right_blank[gi] = blank_q[gi+1];
            end
            assign step_code[gi]      = i_mode[0] ? right_code[gi]  : left_code[gi];
            assign step_blank[gi]     = i_mode[0] ? right_blank[gi] : left_blank[gi];
            assign o_digits[4*gi +: 4] = code_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            code_q   <= '{default: '0};
            blank_q  <= '1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            drop_q   <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            drop_q   <= i_valid && decodable && full_q && !flush;
            step_q   <= 1'b0;
            if (clear_go) begin
                state_q <= S_CLEAR;
                count_q <= '0;
                code_q  <= '{default: '0};
                blank_q <= '1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        count_q <= '0;
                        if (!empty_q && !i_mode[1]) begin
                            state_q <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (i_mode[1]) begin
                            state_q <= S_HOLD;
                        end else if (do_step) begin
                            count_q <= '0;
                            code_q  <= step_code;
                            blank_q <= step_blank;
                            step_q  <= 1'b1;
                            if (empty_q && (&step_blank)) begin
                                state_q <= S_IDLE;
                            end
                        end else begin
                            count_q <= count_q + CW'(1);
                        end
                    end
                    S_HOLD: begin
                        if (!i_mode[1]) begin
                            state_q <= S_RUN;
                        end
                    end
                    S_CLEAR: begin
                        state_q <= S_IDLE;
                        count_q <= '0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign o_ready      = !full_q;
    assign o_fifo_empty = empty_q;
    assign o_drop       = drop_q;
    assign o_step       = step_q;
    assign o_blank      = blank_q;
    assign o_busy       = (state_q == S_RUN) || (state_q == S_HOLD);
endmodule

// File: tb/tb_scroll_display_engine.sv
// Scoreboard bench for scroll_display_engine: a queue model of the FIFO and
// window predicts each step's digits, popped and compared on every o_step.
module tb_scroll_display_engine;
    localparam int N  = 3;
    localparam int D  = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_valid = 1'b0;
    logic [7:0]    i_data = 8'h00;
    logic [1:0]    i_rate = 2'd3;
    logic [1:0]    i_mode = 2'b10;
    logic          o_ready, o_drop, o_step, o_fifo_empty, o_busy;
    logic [4*N-1:0] o_digits;
    logic [N-1:0]  o_blank;

    int tests_run = 0;
    int tests_failed = 0;
    int drop_cnt = 0;

    logic [14:0] sb [$];
    logic [4:0]  mfifo [$];
    logic [11:0] mdig = 12'h000;
    logic [2:0]  mblk = 3'b111;

    scroll_display_engine #(.NUM_DIGITS(N), .FIFO_DEPTH(D), .STEP_CYCLES(SC)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
        .i_rate(i_rate), .i_mode(i_mode), .o_ready(o_ready), .o_drop(o_drop),
        .o_step(o_step), .o_digits(o_digits), .o_blank(o_blank),
        .o_fifo_empty(o_fifo_empty), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_drop) drop_cnt <= drop_cnt + 1;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic model_clear();
        sb.delete();
        mfifo.delete();
        mdig = 12'h000;
        mblk = 3'b111;
    endtask

    task automatic send(input logic [7:0] b);
        i_valid = 1'b1;
        i_data  = b;
        if (b == 8'h20) begin
            if (mfifo.size() < D) mfifo.push_back(5'h10);
        end else if (b >= 8'h30 && b <= 8'h39) begin
            if (mfifo.size() < D) mfifo.push_back({1'b0, 4'(b - 8'h30)});
        end
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    // Predict every step until the window empties and the engine goes idle.
    task automatic model_run(input bit right);
        logic [4:0] head;
        bit was_empty;
        for (int s = 0; s < 20; s++) begin
            was_empty = (mfifo.size() == 0);
            if (was_empty) head = 5'h10;
            else head = mfifo.pop_front();
            if (right) begin
                mdig = {head[3:0], mdig[11:4]};
                mblk = {head[4], mblk[2:1]};
            end else begin
                mdig = {mdig[7:0], head[3:0]};
                mblk = {mblk[1:0], head[4]};
            end
            sb.push_back({mdig, mblk});
            if (was_empty && mblk == 3'b111) break;
        end
    endtask

    task automatic wait_step(input int budget, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (o_step) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (o_digits !== 12'h000) begin tests_failed++; $display("FAIL reset_digits: got %h want 000", o_digits); end
        tests_run++; if (o_blank !== 3'b111) begin tests_failed++; $display("FAIL reset_blank: got %b want 111", o_blank); end
        tests_run++; if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        tests_run++; if (o_fifo_empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b want 1", o_fifo_empty); end
        tests_run++; if (o_busy !== 1'b0 || o_step !== 1'b0 || o_drop !== 1'b0) begin
            tests_failed++; $display("FAIL reset_flags: busy/step/drop got %b%b%b want 000", o_busy, o_step, o_drop);
        end
        reset = 1'b0;
        model_clear();
        $display("[TB] reset checked");
    endtask

    task automatic test_scroll_left();
        bit got; int cyc; logic [14:0] exp;
        i_mode = 2'b10; i_rate = 2'd3;
        send(8'h31); send(8'h32); send(8'h33);
        model_run(1'b0);
        i_mode = 2'b00;
        for (int k = 0; sb.size() > 0; k++) begin
            wait_step(12, got, cyc);
            tests_run++;
            if (!got) begin tests_failed++; $display("FAIL left_step%0d: no o_step within 12 cycles", k); sb.delete(); break; end
            exp = sb.pop_front();
            if ({o_digits, o_blank} !== exp) begin
                tests_failed++; $display("FAIL left_step%0d: digits/blank got %h/%b want %h/%b", k, o_digits, o_blank, exp[14:3], exp[2:0]);
            end
            tests_run++;
            if (cyc !== (k == 0 ? 5 : 4)) begin tests_failed++; $display("FAIL left_interval%0d: got %0d cycles want %0d", k, cyc, (k == 0 ? 5 : 4)); end
            $display("[TB] left step %0d digits=%h blank=%b", k, o_digits, o_blank);
        end
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL left_idle: busy got %b want 0", o_busy); end
    endtask

    task automatic test_scroll_right();
        bit got; int cyc; logic [14:0] exp;
        i_mode = 2'b10; i_rate = 2'd3;
        send(8'h31); send(8'h32); send(8'h33);
        model_run(1'b1);
        i_mode = 2'b01;
        for (int k = 0; sb.size() > 0; k++) begin
            wait_step(12, got, cyc);
            tests_run++;
            if (!got) begin tests_failed++; $display("FAIL right_step%0d: no o_step within 12 cycles", k); sb.delete(); break; end
            exp = sb.pop_front();
            if ({o_digits, o_blank} !== exp) begin
                tests_failed++; $display("FAIL right_step%0d: digits/blank got %h/%b want %h/%b", k, o_digits, o_blank, exp[14:3], exp[2:0]);
            end
            $display("[TB] right step %0d digits=%h blank=%b", k, o_digits, o_blank);
        end
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL right_idle: busy got %b want 0", o_busy); end
    endtask

    task automatic test_overflow();
        bit got; int cyc; int base; logic [14:0] exp;
        i_mode = 2'b10; i_rate = 2'd3;
        base = drop_cnt;
        send(8'h31); send(8'h32); send(8'h33);
        tests_run++; if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL ovf_ready3: got %b want 1", o_ready); end
        send(8'h34);
        tests_run++; if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL ovf_ready4: got %b want 0", o_ready); end
        send(8'h35);
        repeat (2) @(negedge clk);
        tests_run++; if (drop_cnt - base !== 1) begin tests_failed++; $display("FAIL ovf_drop: got %0d pulses want 1", drop_cnt - base); end
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL ovf_hold_idle: busy got %b want 0", o_busy); end
        $display("[TB] overflow drops=%0d ready=%b", drop_cnt - base, o_ready);
        model_run(1'b0);
        i_mode = 2'b00;
        for (int k = 0; sb.size() > 0; k++) begin
            wait_step(12, got, cyc);
            tests_run++;
            if (!got) begin tests_failed++; $display("FAIL ovf_step%0d: no o_step within 12 cycles", k); sb.delete(); break; end
            exp = sb.pop_front();
            if ({o_digits, o_blank} !== exp) begin
                tests_failed++; $display("FAIL ovf_step%0d: digits/blank got %h/%b want %h/%b", k, o_digits, o_blank, exp[14:3], exp[2:0]);
            end
            if (k == 0) begin
                tests_run++; if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL ovf_ready_pop: got %b want 1", o_ready); end
            end
            $display("[TB] overflow drain step %0d digits=%h blank=%b", k, o_digits, o_blank);
        end
        tests_run++; if (o_busy !== 1'b0 || o_fifo_empty !== 1'b1) begin
            tests_failed++; $display("FAIL ovf_end: busy/empty got %b/%b want 0/1", o_busy, o_fifo_empty);
        end
    endtask

    task automatic test_decode();
        bit got; int cyc; int base; logic [14:0] exp;
        i_mode = 2'b10; i_rate = 2'd3;
        base = drop_cnt;
        send(8'h41); send(8'h20); send(8'h37);
        model_run(1'b0);
        i_mode = 2'b00;
        for (int k = 0; sb.size() > 0; k++) begin
            wait_step(12, got, cyc);
            tests_run++;
            if (!got) begin tests_failed++; $display("FAIL dec_step%0d: no o_step within 12 cycles", k); sb.delete(); break; end
            exp = sb.pop_front();
            if ({o_digits, o_blank} !== exp) begin
                tests_failed++; $display("FAIL dec_step%0d: digits/blank got %h/%b want %h/%b", k, o_digits, o_blank, exp[14:3], exp[2:0]);
            end
            $display("[TB] decode step %0d digits=%h blank=%b", k, o_digits, o_blank);
        end
        tests_run++; if (drop_cnt !== base) begin tests_failed++; $display("FAIL dec_nodrop: got %0d pulses want 0", drop_cnt - base); end
    endtask

    task automatic test_rate_clear();
        bit seen; logic [14:0] exp;
        i_mode = 2'b10; i_rate = 2'd0;
        send(8'h31); send(8'h32); send(8'h33);
        model_run(1'b0);
        exp = sb.pop_front();
        i_mode = 2'b00;
        seen = 1'b0;
        repeat (11) begin
            @(negedge clk);
            if (o_step) seen = 1'b1;
        end
        tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL rate_early: o_step seen before rate change, want none"); end
        i_rate = 2'd3;
        @(negedge clk);
        tests_run++; if (o_step !== 1'b1) begin tests_failed++; $display("FAIL rate_step: o_step got %b want 1", o_step); end
        tests_run++; if ({o_digits, o_blank} !== exp) begin
            tests_failed++; $display("FAIL rate_digits: got %h/%b want %h/%b", o_digits, o_blank, exp[14:3], exp[2:0]);
        end
        $display("[TB] rate change step=%b digits=%h", o_step, o_digits);
        i_mode = 2'b11;
        @(negedge clk);
        i_mode = 2'b10;
        tests_run++; if (o_blank !== 3'b111 || o_digits !== 12'h000) begin
            tests_failed++; $display("FAIL clear_blank: got %h/%b want 000/111", o_digits, o_blank);
        end
        @(negedge clk);
        tests_run++; if (o_busy !== 1'b0 || o_fifo_empty !== 1'b1 || o_ready !== 1'b1) begin
            tests_failed++; $display("FAIL clear_idle: busy/empty/ready got %b/%b/%b want 0/1/1", o_busy, o_fifo_empty, o_ready);
        end
        model_clear();
        $display("[TB] clear busy=%b empty=%b", o_busy, o_fifo_empty);
    endtask

    task automatic test_reset_mid_run();
        bit got; int cyc;
        i_mode = 2'b10; i_rate = 2'd3;
        send(8'h34); send(8'h35); send(8'h36);
        i_mode = 2'b00;
        wait_step(12, got, cyc);
        tests_run++; if (!got || o_digits !== 12'h004) begin
            tests_failed++; $display("FAIL rst_run_step: got step=%b digits=%h want 1/004", got, o_digits);
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++; if (o_digits !== 12'h000 || o_blank !== 3'b111) begin
            tests_failed++; $display("FAIL rst_run_digits: got %h/%b want 000/111", o_digits, o_blank);
        end
        tests_run++; if (o_busy !== 1'b0 || o_fifo_empty !== 1'b1 || o_ready !== 1'b1 || o_step !== 1'b0) begin
            tests_failed++; $display("FAIL rst_run_flags: busy/empty/ready/step got %b%b%b%b want 0110", o_busy, o_fifo_empty, o_ready, o_step);
        end
        reset = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_run_stay_idle: busy got %b want 0", o_busy); end
        $display("[TB] reset mid-run digits=%h busy=%b", o_digits, o_busy);
    endtask

    initial begin
        test_reset();
        test_scroll_left();
        test_scroll_right();
        test_overflow();
        test_decode();
        test_rate_clear();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
